// File: rtl/mmio_hub_pkg.sv
// Shared constants and address helpers for the mmio_hub register map.
// Optional feature macro used by this design: MMIO_HUB_DEBOUNCE_EN.
package mmio_hub_pkg;

  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 32;
  localparam int IO_REGION_BIT = 12;

  localparam logic [7:0] OFF_BTN    = 8'h00;
  localparam logic [7:0] OFF_PRESS  = 8'h01;
  localparam logic [7:0] OFF_SHADOW = 8'h10;
  localparam logic [7:0] OFF_COMMIT = 8'h20;

  function automatic logic [3:0] player_of(input logic [ADDR_W-1:0] address);
    return address[11:8];
  endfunction

endpackage

// File: rtl/mmio_hub_if.sv
// Processor data-memory port plus the data-RAM side that mmio_hub sits in front of.
interface mmio_hub_if;
  import mmio_hub_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              wren;
  logic [DATA_W-1:0] data_out;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output address, data_in, wren, ram_q,
    input  data_out, ram_wren
  );

  modport slave (
    input  address, data_in, wren, ram_q,
    output data_out, ram_wren
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser and per-bit debouncer for active-low buttons; outputs are active-high.
// Counters exist only when MMIO_HUB_DEBOUNCE_EN is defined, otherwise the synchronised value passes through.
module button_debouncer #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_n,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  // Reset to released so nothing looks pressed coming out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= raw_n;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef MMIO_HUB_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             state_reg;
    logic             flip;

    always_comb begin
      cnt_next = cnt_reg;
      flip     = 1'b0;
      if (~sync2_reg[gi] == state_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        flip     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_reg   <= '0;
        state_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_next;
        if (flip) state_reg <= ~state_reg;
      end
    end

    // Strobe in the cycle before the state register goes high, so a latch lands with it.
    assign rise[gi]  = flip & ~state_reg;
    assign state[gi] = state_reg;
  end
`else
  assign state = ~sync2_reg;
  assign rise  = ~sync1_reg & sync2_reg;
`endif

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: routes dmem accesses to RAM or per-player button/sprite registers.
// Button debouncing is enabled by defining MMIO_HUB_DEBOUNCE_EN.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int BUTTONS         = 18,
  parameter int VGA_WORDS       = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  mmio_hub_if.slave                           bus,
  input  logic [NUM_PLAYERS*BUTTONS-1:0]      gpio,
  input  logic                                frame_sync,
  output logic [NUM_PLAYERS*VGA_WORDS*32-1:0] pVGA
);

  logic        io_sel;
  logic [3:0]  player;
  logic [7:0]  offset;

  assign io_sel       = bus.address[IO_REGION_BIT];
  assign player       = player_of(bus.address);
  assign offset       = bus.address[7:0];
  assign bus.ram_wren = bus.wren & ~io_sel;

  // frame_sync crosses domains; the edge register adds the third cycle of latency.
  logic fs_sync1_reg;
  logic fs_sync2_reg;
  logic frame_edge_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fs_sync1_reg   <= 1'b1;
      fs_sync2_reg   <= 1'b1;
      frame_edge_reg <= 1'b0;
    end else begin
      fs_sync1_reg   <= frame_sync;
      fs_sync2_reg   <= fs_sync1_reg;
      frame_edge_reg <= fs_sync1_reg & ~fs_sync2_reg;
    end
  end

  logic [NUM_PLAYERS*BUTTONS-1:0] btn_state;
  logic [NUM_PLAYERS*BUTTONS-1:0] btn_rise;
  logic [NUM_PLAYERS*32-1:0]      player_rdata;

  genvar gi, wi;
  for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic               hit;
    logic               wr_hit;
    logic               press_clr;
    logic               commit_wr;
    logic               copy;
    logic [BUTTONS-1:0] press_reg;
    logic               pending_reg;
    logic [31:0]        shadow_reg [VGA_WORDS];
    logic [31:0]        live_reg   [VGA_WORDS];
    logic [31:0]        rdata;

    button_debouncer #(
      .WIDTH           (BUTTONS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock (clock),
      .reset (reset),
      .raw_n (gpio[gi*BUTTONS +: BUTTONS]),
      .state (btn_state[gi*BUTTONS +: BUTTONS]),
      .rise  (btn_rise[gi*BUTTONS +: BUTTONS])
    );

    assign hit       = io_sel && (player == 4'(gi));
    assign wr_hit    = hit & bus.wren;
    assign press_clr = hit & ~bus.wren & (offset == OFF_PRESS);
    assign commit_wr = wr_hit & (offset == OFF_COMMIT) & bus.data_in[0];
    // A commit coinciding with the frame edge defers the copy to the next edge.
    assign copy      = frame_edge_reg & pending_reg & ~commit_wr;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        press_reg   <= '0;
        pending_reg <= 1'b0;
      end else begin
        press_reg <= (press_reg & ~{BUTTONS{press_clr}}) | btn_rise[gi*BUTTONS +: BUTTONS];
        if (commit_wr)
          pending_reg <= 1'b1;
        else if (copy)
          pending_reg <= 1'b0;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int w = 0; w < VGA_WORDS; w++) begin
          shadow_reg[w] <= '0;
          live_reg[w]   <= '0;
        end
      end else begin
        for (int w = 0; w < VGA_WORDS; w++) begin
          if (wr_hit && (offset == OFF_SHADOW + 8'(w)))
            shadow_reg[w] <= bus.data_in;
          if (copy)
            live_reg[w] <= shadow_reg[w];
        end
      end
    end

    for (wi = 0; wi < VGA_WORDS; wi++) begin : g_word
      assign pVGA[(gi*VGA_WORDS+wi)*32 +: 32] = live_reg[wi];
    end

    always_comb begin
      rdata = '0;
      if (hit) begin
        case (offset)
          OFF_BTN:    rdata = 32'(btn_state[gi*BUTTONS +: BUTTONS]);
          OFF_PRESS:  rdata = 32'(press_reg);
          OFF_COMMIT: rdata = {31'b0, pending_reg};
          default: begin
            for (int w = 0; w < VGA_WORDS; w++)
              if (offset == OFF_SHADOW + 8'(w)) rdata = shadow_reg[w];
          end
        endcase
      end
    end

    assign player_rdata[gi*32 +: 32] = rdata;
  end

  // Each player's rdata is already gated by its own hit, so OR-ing is a mux.
  logic [31:0] io_rdata;
  always_comb begin
    io_rdata = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      io_rdata = io_rdata | player_rdata[p*32 +: 32];
  end

  logic        sel_io_reg;
  logic [31:0] io_rdata_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_io_reg   <= 1'b1;
      io_rdata_reg <= '0;
    end else begin
      sel_io_reg   <= io_sel;
      io_rdata_reg <= io_rdata;
    end
  end

  assign bus.data_out = sel_io_reg ? io_rdata_reg : bus.ram_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub with a small registered-read RAM model behind it.
module tb_mmio_hub;

`ifdef MMIO_HUB_DEBOUNCE_EN
  localparam int LAT = 18;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit DEB = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [35:0]  gpio;
  logic         frame_sync;
  logic [319:0] pVGA;
  int           total;
  int           bad;

  mmio_hub_if bus ();

  mmio_hub #(
    .NUM_PLAYERS     (2),
    .BUTTONS         (18),
    .VGA_WORDS       (5),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .bus        (bus.slave),
    .gpio       (gpio),
    .frame_sync (frame_sync),
    .pVGA       (pVGA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.address[11:0]] <= bus.data_in;
    bus.ram_q <= mem[bus.address[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("txn %s: got %h want %h", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [12:0] a, input string tag, input logic [31:0] exp);
    bus.address = a;
    bus.wren    = 1'b0;
    tick();
    check(tag, bus.data_out, exp);
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d);
    bus.address = a;
    bus.data_in = d;
    bus.wren    = 1'b1;
    tick();
    bus.wren    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.address = '0;
    bus.data_in = '0;
    bus.wren    = 1'b0;
    gpio        = '1;
    frame_sync  = 1'b0;
    repeat (3) tick();
    check("rst_dout", bus.data_out, 32'h0);
    check("rst_pvga", {31'b0, |pVGA}, 32'h0);
    rst = 1'b0;
    tick();

    rd(13'h1000, "rst_btn", 32'h0);
    rd(13'h1001, "rst_press", 32'h0);
    rd(13'h1020, "rst_commit", 32'h0);

    // Stable press on player 0 bit 3
    bus.address = 13'h1000;
    gpio[3] = 1'b0;
    repeat (LAT) tick();
    check("btn_early", bus.data_out, 32'h0);
    tick();
    check("btn_on", bus.data_out, 32'h8);
    rd(13'h1001, "press_set", 32'h8);
    rd(13'h1001, "press_clr", 32'h0);
    gpio[3] = 1'b1;
    repeat (LAT + 2) tick();
    rd(13'h1000, "btn_rel", 32'h0);
    rd(13'h1001, "press_rel", 32'h0);

    // 10-cycle glitch on bit 0
    bus.address = 13'h1000;
    gpio[0] = 1'b0;
    repeat (3) tick();
    check("glitch_btn", bus.data_out, DEB ? 32'h0 : 32'h1);
    repeat (7) tick();
    gpio[0] = 1'b1;
    repeat (LAT + 4) tick();
    rd(13'h1000, "glitch_btn_after", 32'h0);
    rd(13'h1001, "glitch_press", DEB ? 32'h0 : 32'h1);

    // Shadow, commit, frame publish for player 1
    wr(13'h1110, 32'hDEADBEEF);
    rd(13'h1110, "shadow_rb", 32'hDEADBEEF);
    check("live_before", pVGA[191:160], 32'h0);
    wr(13'h1120, 32'h1);
    rd(13'h1120, "commit_pend", 32'h1);
    frame_sync = 1'b1;
    tick();
    tick();
    check("live_early", pVGA[191:160], 32'h0);
    tick();
    check("live_copy", pVGA[191:160], 32'hDEADBEEF);
    frame_sync = 1'b0;
    rd(13'h1120, "commit_clr", 32'h0);

    // Commit coinciding with frame_edge defers the copy
    wr(13'h1111, 32'hCAFE0001);
    frame_sync = 1'b1;
    tick();
    tick();
    bus.address = 13'h1120;
    bus.data_in = 32'h1;
    bus.wren    = 1'b1;
    tick();
    bus.wren    = 1'b0;
    check("same_nocopy", pVGA[223:192], 32'h0);
    frame_sync = 1'b0;
    rd(13'h1120, "same_pend", 32'h1);
    repeat (2) tick();
    frame_sync = 1'b1;
    tick();
    tick();
    // Shadow write in the copy cycle must not reach LIVE
    bus.address = 13'h1111;
    bus.data_in = 32'h00005555;
    bus.wren    = 1'b1;
    tick();
    bus.wren    = 1'b0;
    frame_sync  = 1'b0;
    check("copy_old", pVGA[223:192], 32'hCAFE0001);
    check("word0_kept", pVGA[191:160], 32'hDEADBEEF);
    rd(13'h1111, "shadow_new", 32'h00005555);
    rd(13'h1120, "commit_done", 32'h0);

    // Unmapped and out-of-range player
    bus.address = 13'h1F00;
    bus.data_in = 32'hFFFFFFFF;
    bus.wren    = 1'b1;
    #1;
    check("io_no_ramwren", {31'b0, bus.ram_wren}, 32'h0);
    tick();
    bus.wren = 1'b0;
    wr(13'h1F10, 32'h12345678);
    rd(13'h1F10, "bad_player", 32'h0);
    rd(13'h1005, "unmapped", 32'h0);

    // RAM path
    bus.address = 13'h0040;
    bus.data_in = 32'h00001234;
    bus.wren    = 1'b1;
    #1;
    check("ram_wren", {31'b0, bus.ram_wren}, 32'h1);
    tick();
    bus.wren = 1'b0;
    rd(13'h0040, "ram_rd", 32'h00001234);

    // Reset with a pending commit
    wr(13'h1020, 32'h1);
    rd(13'h1020, "p0_pend", 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_live", pVGA[191:160], 32'h0);
    rd(13'h1020, "rst_lost", 32'h0);
    rd(13'h1110, "rst_shadow", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised successor to the two-player memory-mapped I/O block. It sits between the processor's data-memory port and the data RAM, and it serves NUM_PLAYERS controllers. For each player it provides synchronised, debounced button state, read-to-clear press latches, and double-buffered VGA sprite-state words. The staged words are published to the VGA controller only at a frame boundary, so the display never shows a half-updated frame.

## Interface
- NUM_PLAYERS, 2: number of controller/sprite channels, 1..16.
- BUTTONS, 18: GPIO inputs per player, 1..32.
- VGA_WORDS, 5: 32-bit sprite-state words per player, 1..16.
- DEBOUNCE_CYCLES, 16: number of consecutive stable cycles required before the debounced state changes, ≥1.
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  13  processor dmem address.
- data_in  in  32  processor write data.
- wren  in  1  processor write enable.
- data_out  out  32  read data, one-cycle latency.
- ram_wren  out  1  write enable to the data RAM.
- ram_q  in  32  data RAM output (synchronous, one-cycle latency).
- gpio  in  NUM_PLAYERS*BUTTONS  raw buttons, active-low; player p occupies bits [p*BUTTONS +: BUTTONS].
- frame_sync  in  1  VGA vsync, asynchronous to clock.
- pVGA  out  NUM_PLAYERS*VGA_WORDS*32  live sprite words; player p word w is at bits [(p*VGA_WORDS+w)*32 +: 32].

## Operation
- Region decode: address[12]=0 selects RAM. In that case ram_wren=wren. I/O writes never reach RAM.
- Within the I/O region, address[11:8] selects the player and address[7:0] selects the register:
  - 0x00 BTN (R): debounced, inverted buttons (1 = pressed), zero-extended to 32 bits.
  - 0x01 PRESS (R, read-to-clear): sticky per-bit latch that is set on a debounced 0→1 transition.
  - 0x10+w SHADOW[w] (R/W): staged sprite word, for w < VGA_WORDS.
  - 0x20 COMMIT: a write with data_in[0]=1 sets pending. A read returns {31'b0, pending}.
- Reads of an unmapped offset, or of a player ≥ NUM_PLAYERS, return 0. Writes to those locations are ignored.
- Input path: gpio passes through a 2-flop synchroniser, then the debouncer. The debounced bit takes the synchronised value only after the two have differed for DEBOUNCE_CYCLES consecutive cycles. Any agreement in between resets that bit's counter.
- PRESS latch:
  - Set on a rising edge of the debounced bit.
  - Cleared in the cycle a PRESS read is accepted.
  - If a set and a clear occur in the same cycle, set wins. The read returns the pre-clear value.
- frame_sync passes through a 2-flop synchroniser and a rising-edge detector, producing frame_edge.
- On frame_edge with pending=1:
  - All SHADOW words for that player copy to LIVE.
  - pending clears.
- Commit and frame_edge in the same cycle: pending is set and no copy happens that cycle. The copy waits for the next frame_edge.
- A SHADOW write while pending=1 is allowed. The copy uses the latest value.
- A SHADOW write in the same cycle as a copy is not included in that copy.
- pVGA is driven directly from the LIVE registers.

## Timing
- Reset values:
  - data_out = 0, pVGA = 0, ram_wren follows wren.
  - All SHADOW, LIVE, pending, PRESS and debouncer state = 0.
  - Synchronisers reset to 1 (released), so no presses are reported out of reset.
- Read latency: data_out is valid in the cycle after address is presented, for both RAM and I/O. The region select and the I/O read data are registered together.
- Write latency: register contents update at the clock edge where wren=1.
- Button latency: BTN reflects a stable change 2 + DEBOUNCE_CYCLES cycles after the gpio edge. PRESS is set in the same cycle.
- Frame latency: LIVE updates 3 cycles after the frame_sync rising edge (2 synchroniser cycles plus the edge register).
- Reset asserted mid-frame or mid-debounce: all state returns to reset values immediately. A pending commit is lost.

## Configuration
- MMIO_HUB_DEBOUNCE_EN defined: debounce counters are instantiated as described above.
- MMIO_HUB_DEBOUNCE_EN undefined: the debounced value equals the synchronised value, so button latency is 2 cycles. DEBOUNCE_CYCLES is ignored and no counters are synthesised.

## Structure
- Package mmio_hub_pkg contains:
  - IO_REGION_BIT = 12.
  - Offsets OFF_BTN = 8'h00, OFF_PRESS = 8'h01, OFF_SHADOW = 8'h10, OFF_COMMIT = 8'h20.
  - Function player_of(address).
- Sub-module button_debouncer (parameters WIDTH and DEBOUNCE_CYCLES) contains the synchroniser, the counters and the rising-edge output. mmio_hub instantiates it once per player.

## Test plan
- Reset, then read 0x1000 and 0x1001 → data_out = 0 one cycle later; pVGA = 0.
- Hold gpio bit 3 low for 20 cycles with DEBOUNCE_CYCLES=16 → BTN = 0x8 at cycle 18. A PRESS read returns 0x8; a second PRESS read returns 0.
- Apply a 10-cycle glitch on gpio bit 0 → BTN and PRESS stay 0. With the macro undefined, BTN bit 0 = 1 from cycle 2 to cycle 11.
- Write SHADOW[0]=0xDEADBEEF for player 1 (address 0x1110) and write COMMIT, then pulse frame_sync → pVGA[191:160] = 0xDEADBEEF 3 cycles after the edge, and COMMIT reads 0.
- Write COMMIT in the same cycle as frame_edge → no copy; the copy happens at the following frame_edge.
- Write 0x1234 to address 0x0040, then read it back → ram_wren pulses, data_out = ram_q after one cycle. A write to 0x1F00 changes nothing.
